// File: rtl/rv32i_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// rv32i_dmem_ctrl
//   Data-memory sequencer for the RV32I MEM stage plus a DMA port, sharing one
//   single-port, word-wide RAM with a registered read (data one cycle after
//   m_en & !m_we). Requests are arbitrated round-robin. Misaligned accesses
//   that cross a word boundary become two word transactions (A, then A+1 with
//   wrap). Store data is lane-steered with byte strobes; load data is
//   reassembled from the two words, truncated and sign/zero extended.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   core_req/acc/adr/sz/s_us/wdata core request (acc 01=load, 10=store)
//   core_ready/rdata/err           one-cycle completion, load data, size error
//   dma_req/we/adr/wdata           DMA word request (address bits [1:0] ignored)
//   dma_ready/rdata                one-cycle completion, read data
//   m_en/we/wstrb/adr/wdata        RAM command (all zero while m_en=0)
//   m_rdata                        RAM read data
// -----------------------------------------------------------------------------
module rv32i_dmem_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic [1:0]        core_acc,
  input  logic [31:0]       core_adr,
  input  logic [1:0]        core_sz,
  input  logic              core_s_us,
  input  logic [31:0]       core_wdata,
  output logic              core_ready,
  output logic [31:0]       core_rdata,
  output logic              core_err,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [31:0]       dma_adr,
  input  logic [31:0]       dma_wdata,
  output logic              dma_ready,
  output logic [31:0]       dma_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [3:0]        m_wstrb,
  output logic [ADDR_W-1:0] m_adr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata
);

  localparam logic [1:0] ACC_LD = 2'b01;
  localparam logic [1:0] ACC_ST = 2'b10;
  localparam logic [1:0] SZ_ILL = 2'b11;

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, WR_B, RESP} state_t;

  state_t state, state_nxt;

  // control
  logic last_dma;

  // request selected in IDLE
  logic              core_v, dma_v, pick_dma, accept;
  logic              sel_store, sel_err, sel_sus, sel_span;
  logic [1:0]        sel_sz, sel_off;
  logic [ADDR_W-1:0] sel_adr_a;
  logic [31:0]       sel_wdata;

  // latched request and captured read words
  logic              gnt_dma, req_store, req_err, req_sus, req_span;
  logic [1:0]        req_sz, req_off;
  logic [ADDR_W-1:0] req_adr_a;
  logic [31:0]       req_wdata, word_a, word_b;

  // Only the word-address field of the byte address is decoded.
  logic unused_adr_bits;
  assign unused_adr_bits = ^{core_adr[31:ADDR_W+2], dma_adr[31:ADDR_W+2], dma_adr[1:0]};

  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // True when the last byte touched lies beyond byte 3 of word A.
  function automatic logic spans(input logic [1:0] off, input logic [1:0] sz);
    logic [2:0] nbytes;
    logic [2:0] end_pos;
    case (sz)
      2'b00:   nbytes = 3'd1;
      2'b01:   nbytes = 3'd2;
      default: nbytes = 3'd4;
    endcase
    end_pos = {1'b0, off} + nbytes;
    return end_pos > 3'd4;
  endfunction

  // Store data shifted into a two-word window; hi selects the word-B half.
  function automatic logic [31:0] lane_data(input logic [31:0] wdata, input logic [1:0] off,
                                            input logic hi);
    logic [63:0] pair;
    pair = {32'b0, wdata} << {off, 3'b000};
    return hi ? pair[63:32] : pair[31:0];
  endfunction

  function automatic logic [3:0] lane_strb(input logic [1:0] sz, input logic [1:0] off,
                                           input logic hi);
    logic [7:0] pair;
    pair = {4'b0, size_mask(sz)} << off;
    return hi ? pair[7:4] : pair[3:0];
  endfunction

  // Little-endian extraction from {word B, word A}, then truncate and extend.
  function automatic logic [31:0] load_extend(input logic [63:0] pair, input logic [1:0] off,
                                              input logic [1:0] sz, input logic zext);
    logic [31:0] w;
    w = 32'(pair >> {off, 3'b000});
    case (sz)
      2'b00:   return zext ? {24'b0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
      2'b01:   return zext ? {16'b0, w[15:0]} : {{16{w[15]}}, w[15:0]};
      default: return w;
    endcase
  endfunction

  // Round-robin: on a tie the requester that did not win last time is granted.
  always_comb begin
    core_v    = core_req && (core_acc == ACC_LD || core_acc == ACC_ST);
    dma_v     = dma_req;
    pick_dma  = dma_v && (!core_v || !last_dma);
    accept    = core_v || dma_v;
    sel_store = pick_dma ? dma_we : (core_acc == ACC_ST);
    sel_sz    = pick_dma ? 2'b10 : core_sz;
    sel_off   = pick_dma ? 2'b00 : core_adr[1:0];
    sel_adr_a = pick_dma ? dma_adr[ADDR_W+1:2] : core_adr[ADDR_W+1:2];
    sel_wdata = pick_dma ? dma_wdata : core_wdata;
    sel_sus   = core_s_us;
    sel_err   = !pick_dma && (core_sz == SZ_ILL);
    sel_span  = spans(sel_off, sel_sz);
  end

  // Control state
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last_dma <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state == RESP) last_dma <= gnt_dma;
    end
  end

  // Request latch and read-data capture
  always_ff @(posedge clk) begin
    if (state == IDLE && accept) begin
      gnt_dma   <= pick_dma;
      req_store <= sel_store;
      req_err   <= sel_err;
      req_sus   <= sel_sus;
      req_span  <= sel_span;
      req_sz    <= sel_sz;
      req_off   <= sel_off;
      req_adr_a <= sel_adr_a;
      req_wdata <= sel_wdata;
    end
    if (state == RD_A) word_a <= m_rdata;
    if (state == RD_B) word_b <= m_rdata;
  end

  // Next state and outputs; reset holds every output low.
  always_comb begin
    state_nxt  = state;
    core_ready = 1'b0;
    core_rdata = '0;
    core_err   = 1'b0;
    dma_ready  = 1'b0;
    dma_rdata  = '0;
    m_en       = 1'b0;
    m_we       = 1'b0;
    m_wstrb    = '0;
    m_adr      = '0;
    m_wdata    = '0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (sel_err) begin
              state_nxt = RESP;
            end else begin
              m_en  = 1'b1;
              m_adr = sel_adr_a;
              if (sel_store) begin
                m_we      = 1'b1;
                m_wstrb   = lane_strb(sel_sz, sel_off, 1'b0);
                m_wdata   = lane_data(sel_wdata, sel_off, 1'b0);
                state_nxt = sel_span ? WR_B : RESP;
              end else begin
                state_nxt = RD_A;
              end
            end
          end
        end
        RD_A: begin
          if (req_span) begin
            m_en      = 1'b1;
            m_adr     = req_adr_a + ADDR_W'(1);
            state_nxt = RD_B;
          end else begin
            state_nxt = RESP;
          end
        end
        RD_B: state_nxt = RESP;
        WR_B: begin
          m_en      = 1'b1;
          m_we      = 1'b1;
          m_adr     = req_adr_a + ADDR_W'(1);
          m_wstrb   = lane_strb(req_sz, req_off, 1'b1);
          m_wdata   = lane_data(req_wdata, req_off, 1'b1);
          state_nxt = RESP;
        end
        RESP: begin
          if (gnt_dma) begin
            dma_ready = 1'b1;
            dma_rdata = req_store ? '0 : word_a;
          end else begin
            core_ready = 1'b1;
            core_err   = req_err;
            core_rdata = (req_store || req_err) ? '0
                       : load_extend({word_b, word_a}, req_off, req_sz, req_sus);
          end
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_dmem_ctrl.sv
module tb_rv32i_dmem_ctrl;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              core_req;
  logic [1:0]        core_acc;
  logic [31:0]       core_adr;
  logic [1:0]        core_sz;
  logic              core_s_us;
  logic [31:0]       core_wdata;
  logic              core_ready;
  logic [31:0]       core_rdata;
  logic              core_err;
  logic              dma_req;
  logic              dma_we;
  logic [31:0]       dma_adr;
  logic [31:0]       dma_wdata;
  logic              dma_ready;
  logic [31:0]       dma_rdata;
  logic              m_en;
  logic              m_we;
  logic [3:0]        m_wstrb;
  logic [ADDR_W-1:0] m_adr;
  logic [31:0]       m_wdata;
  logic [31:0]       m_rdata;

  always #5 clk = ~clk;

  rv32i_dmem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_acc(core_acc), .core_adr(core_adr), .core_sz(core_sz),
    .core_s_us(core_s_us), .core_wdata(core_wdata), .core_ready(core_ready),
    .core_rdata(core_rdata), .core_err(core_err),
    .dma_req(dma_req), .dma_we(dma_we), .dma_adr(dma_adr), .dma_wdata(dma_wdata),
    .dma_ready(dma_ready), .dma_rdata(dma_rdata),
    .m_en(m_en), .m_we(m_we), .m_wstrb(m_wstrb), .m_adr(m_adr), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  // RAM model: registered read, byte-strobed write, preload while mem_load=1.
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  logic        mem_load;

  always @(posedge clk) begin
    if (mem_load) begin
      mem[0]   <= 32'h44332211;
      mem[1]   <= 32'h88776655;
      mem[255] <= 32'hDDCCBBAA;
    end else if (m_en) begin
      if (m_we) begin
        for (int i = 0; i < 4; i++)
          if (m_wstrb[i]) mem[m_adr][8*i +: 8] <= m_wdata[8*i +: 8];
      end else begin
        m_rdata <= mem[m_adr];
      end
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  // Trace of RAM commands issued during one transaction.
  int          tr_n;
  logic        tr_we [4];
  logic [7:0]  tr_ad [4];
  logic [3:0]  tr_st [4];
  logic [31:0] tr_wd [4];

  typedef struct {
    logic [1:0]  sz;
    logic        sus;
    logic [31:0] adr;
    logic [31:0] exp;
    int          lat;
    int          nacc;
    logic        err;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic trace_clear();
    tr_n = 0;
    for (int i = 0; i < 4; i++) begin
      tr_we[i] = 1'bx; tr_ad[i] = 'x; tr_st[i] = 'x; tr_wd[i] = 'x;
    end
  endtask

  task automatic trace_sample();
    if (m_en && tr_n < 4) begin
      tr_we[tr_n] = m_we; tr_ad[tr_n] = m_adr; tr_st[tr_n] = m_wstrb; tr_wd[tr_n] = m_wdata;
      tr_n++;
    end
  endtask

  task automatic do_core(input logic [1:0] acc, input logic [31:0] adr, input logic [1:0] sz,
                         input logic sus, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd, output logic er);
    @(negedge clk);
    core_req = 1'b1; core_acc = acc; core_adr = adr; core_sz = sz;
    core_s_us = sus; core_wdata = wd;
    trace_clear();
    lat = -1; rd = 'x; er = 1'bx;
    for (int c = 0; c < 12; c++) begin
      #1;
      trace_sample();
      if (core_ready) begin
        lat = c; rd = core_rdata; er = core_err;
        break;
      end
      @(negedge clk);
    end
    core_req = 1'b0; core_acc = 2'b00;
  endtask

  task automatic do_dma(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd);
    @(negedge clk);
    dma_req = 1'b1; dma_we = we; dma_adr = adr; dma_wdata = wd;
    trace_clear();
    lat = -1; rd = 'x;
    for (int c = 0; c < 12; c++) begin
      #1;
      trace_sample();
      if (dma_ready) begin
        lat = c; rd = dma_rdata;
        break;
      end
      @(negedge clk);
    end
    dma_req = 1'b0;
  endtask

  // Core LW @0 and DMA read @4 both held: expect C,D,C,D at cycles 2,5,8,11.
  task automatic arb_run(input string tag, input logic [31:0] exp_c, input logic [31:0] exp_d);
    int          ne;
    int          who [4];
    int          cyc [4];
    logic [31:0] dat [4];
    @(negedge clk);
    core_req = 1'b1; core_acc = 2'b01; core_adr = 32'h0; core_sz = 2'b10; core_s_us = 1'b0;
    dma_req = 1'b1; dma_we = 1'b0; dma_adr = 32'h4;
    ne = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (core_ready && dma_ready) begin
        n_chk++; n_fail++;
        $display("FAIL %s both_ready: both ports ready in cycle %0d, required one", tag, c);
      end
      if (core_ready && ne < 4) begin who[ne] = 0; cyc[ne] = c; dat[ne] = core_rdata; ne++; end
      else if (dma_ready && ne < 4) begin who[ne] = 1; cyc[ne] = c; dat[ne] = dma_rdata; ne++; end
      if (ne == 4) break;
      @(negedge clk);
    end
    core_req = 1'b0; core_acc = 2'b00; dma_req = 1'b0;
    chk({tag, " events"}, 32'(ne), 32'd4);
    for (int k = 0; k < ne; k++) begin
      chk($sformatf("%s ev%0d owner", tag, k), 32'(who[k]), 32'(k % 2));
      chk($sformatf("%s ev%0d cycle", tag, k), 32'(cyc[k]), 32'(2 + 3*k));
      chk($sformatf("%s ev%0d data", tag, k), dat[k], (k % 2 == 0) ? exp_c : exp_d);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        er;
    logic [31:0] a;
    logic [7:0]  ea;
    logic        seen;

    vt[0]  = '{2'b10, 1'b0, 32'h000, 32'h44332211, 2, 1, 1'b0};
    vt[1]  = '{2'b10, 1'b0, 32'h003, 32'h77665544, 3, 2, 1'b0};
    vt[2]  = '{2'b01, 1'b0, 32'h003, 32'h00005544, 3, 2, 1'b0};
    vt[3]  = '{2'b00, 1'b0, 32'h003, 32'h00000044, 2, 1, 1'b0};
    vt[4]  = '{2'b01, 1'b0, 32'h002, 32'h00004433, 2, 1, 1'b0};
    vt[5]  = '{2'b00, 1'b0, 32'h005, 32'h00000066, 2, 1, 1'b0};
    vt[6]  = '{2'b01, 1'b0, 32'h006, 32'hFFFF8877, 2, 1, 1'b0};
    vt[7]  = '{2'b01, 1'b1, 32'h006, 32'h00008877, 2, 1, 1'b0};
    vt[8]  = '{2'b00, 1'b0, 32'h007, 32'hFFFFFF88, 2, 1, 1'b0};
    vt[9]  = '{2'b10, 1'b0, 32'h3FE, 32'h2211DDCC, 3, 2, 1'b0};
    vt[10] = '{2'b11, 1'b0, 32'h000, 32'h00000000, 1, 0, 1'b1};
    vt[11] = '{2'b10, 1'b0, 32'h402, 32'h66554433, 3, 2, 1'b0};

    core_req = 0; core_acc = 0; core_adr = 0; core_sz = 0; core_s_us = 0; core_wdata = 0;
    dma_req = 0; dma_we = 0; dma_adr = 0; dma_wdata = 0;
    rst = 1'b1; mem_load = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0; mem_load = 1'b0;
    #1;
    chk("reset ready", {30'b0, core_ready, dma_ready}, 32'h0);
    chk("reset err/m_en/m_we", {29'b0, core_err, m_en, m_we}, 32'h0);
    chk("reset core_rdata", core_rdata, 32'h0);
    chk("reset dma_rdata", dma_rdata, 32'h0);
    chk("reset m_bus", {20'b0, m_wstrb, m_adr} | m_wdata, 32'h0);

    arb_run("arb1", 32'h44332211, 32'h88776655);

    for (int i = 0; i < 12; i++) begin
      do_core(2'b01, vt[i].adr, vt[i].sz, vt[i].sus, 32'h0, lat, rd, er);
      a  = vt[i].adr;
      ea = a[9:2];
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vt[i].lat));
      chk($sformatf("vec%0d rdata", i), rd, vt[i].exp);
      chk($sformatf("vec%0d err", i), {31'b0, er}, {31'b0, vt[i].err});
      chk($sformatf("vec%0d ram accesses", i), 32'(tr_n), 32'(vt[i].nacc));
      if (tr_n > 0) begin
        chk($sformatf("vec%0d word A", i), {24'b0, tr_ad[0]}, {24'b0, ea});
        chk($sformatf("vec%0d A is read", i), {31'b0, tr_we[0]}, 32'h0);
      end
      if (tr_n > 1)
        chk($sformatf("vec%0d word B", i), {24'b0, tr_ad[1]}, {24'b0, ea + 8'd1});
    end

    // SH 0xBEEF @3: split store across words 0 and 1
    do_core(2'b10, 32'h3, 2'b01, 1'b0, 32'h0000BEEF, lat, rd, er);
    chk("sh latency", 32'(lat), 32'd2);
    chk("sh accesses", 32'(tr_n), 32'd2);
    chk("sh A adr/strb", {20'b0, tr_ad[0], tr_st[0]}, {20'b0, 8'd0, 4'b1000});
    chk("sh A byte", {24'b0, tr_wd[0][31:24]}, 32'hEF);
    chk("sh B adr/strb", {20'b0, tr_ad[1], tr_st[1]}, {20'b0, 8'd1, 4'b0001});
    chk("sh B byte", {24'b0, tr_wd[1][7:0]}, 32'hBE);
    chk("sh writes", {30'b0, tr_we[0], tr_we[1]}, 32'h3);
    do_core(2'b01, 32'h0, 2'b10, 1'b0, 32'h0, lat, rd, er);
    chk("sh word0", rd, 32'hEF332211);
    do_core(2'b01, 32'h4, 2'b10, 1'b0, 32'h0, lat, rd, er);
    chk("sh word1", rd, 32'h887766BE);

    // SB 0x80 @3 then signed/unsigned byte loads
    do_core(2'b10, 32'h3, 2'b00, 1'b0, 32'h00000080, lat, rd, er);
    chk("sb latency", 32'(lat), 32'd1);
    chk("sb strb", {28'b0, tr_st[0]}, 32'h8);
    do_core(2'b01, 32'h3, 2'b00, 1'b0, 32'h0, lat, rd, er);
    chk("lb signed 0x80", rd, 32'hFFFFFF80);
    do_core(2'b01, 32'h3, 2'b00, 1'b1, 32'h0, lat, rd, er);
    chk("lbu 0x80", rd, 32'h00000080);

    // SW @1: A strobe 1110, B strobe 0001, then read back split
    do_core(2'b10, 32'h1, 2'b10, 1'b0, 32'hA1B2C3D4, lat, rd, er);
    chk("sw latency", 32'(lat), 32'd2);
    chk("sw strobes", {24'b0, tr_st[0], tr_st[1]}, {24'b0, 4'b1110, 4'b0001});
    chk("sw A bytes", {8'b0, tr_wd[0][31:8]}, 32'h00B2C3D4);
    chk("sw B byte", {24'b0, tr_wd[1][7:0]}, 32'hA1);
    do_core(2'b01, 32'h1, 2'b10, 1'b0, 32'h0, lat, rd, er);
    chk("lw@1 latency", 32'(lat), 32'd3);
    chk("lw@1 data", rd, 32'hA1B2C3D4);

    // DMA write then read with ignored low address bits
    do_dma(1'b1, 32'h8, 32'hCAFEF00D, lat, rd);
    chk("dma wr latency", 32'(lat), 32'd1);
    chk("dma wr cmd", {19'b0, tr_we[0], tr_ad[0], tr_st[0]}, {19'b0, 1'b1, 8'd2, 4'hF});
    chk("dma wr data", tr_wd[0], 32'hCAFEF00D);
    do_dma(1'b0, 32'hB, 32'h0, lat, rd);
    chk("dma rd latency", 32'(lat), 32'd2);
    chk("dma rd data", rd, 32'hCAFEF00D);

    // Reset during RD_B of a split load
    @(negedge clk);
    core_req = 1'b1; core_acc = 2'b01; core_adr = 32'h3; core_sz = 2'b10; core_s_us = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; core_req = 1'b0; core_acc = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst outputs", {29'b0, core_ready, dma_ready, m_en}, 32'h0);
    chk("midrst err", {31'b0, core_err}, 32'h0);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk); #1;
      if (core_ready || m_en) seen = 1'b1;
    end
    chk("midrst no ready", {31'b0, seen}, 32'h0);

    arb_run("arb2", 32'hB2C3D411, 32'h887766A1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
